// File: rtl/clock_time_if.sv
// Button and display bundle between the clock time controller and its user side.
// Buttons are debounced single-cycle pulses, sampled on the rising clock edge; there is no back-pressure.
interface clock_time_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] sec1;
  logic [3:0] sec2;
  logic [3:0] min1;
  logic [3:0] min2;
  logic [3:0] hour1;
  logic [3:0] hour2;
  logic       ampm;
  logic [1:0] mode;
  logic       tick_1hz;
  logic [3:0] blank;

  modport master (
    output btn_mode, btn_inc,
    input  sec1, sec2, min1, min2, hour1, hour2, ampm, mode, tick_1hz, blank
  );

  modport slave (
    input  btn_mode, btn_inc,
    output sec1, sec2, min1, min2, hour1, hour2, ampm, mode, tick_1hz, blank
  );
endinterface

// File: rtl/clock_time_controller.sv
// 12-hour BCD timekeeper with a RUN / SET_HOUR / SET_MIN button sequencer.
// Optional macro CLOCK_SET_BLINK_EN blinks the field being set; otherwise blank is 4'b0000.
module clock_time_controller #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  clock_time_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick_q;
  mode_e         mode_q;
  mode_e         mode_nxt;
  logic [3:0]    sec1_q, sec2_q, min1_q, min2_q, hour1_q, hour2_q;
  logic          ampm_q;
  logic [3:0]    hour1_nxt, hour2_nxt;
  logic          ampm_nxt;

  logic sec_wrap, min_wrap, exit_set, adv_sec, inc_min, inc_hour;

  assign sec_wrap = (sec2_q == 4'd5) && (sec1_q == 4'd9);
  assign min_wrap = (min2_q == 4'd5) && (min1_q == 4'd9);
  assign exit_set = bus.btn_mode && (mode_q == SET_MIN);
  // A mode press always wins over the tick or inc arriving in the same cycle.
  assign adv_sec  = !bus.btn_mode && (mode_q == RUN) && tick_q;
  assign inc_min  = (adv_sec && sec_wrap) ||
                    (!bus.btn_mode && (mode_q == SET_MIN) && bus.btn_inc);
  assign inc_hour = (adv_sec && sec_wrap && min_wrap) ||
                    (!bus.btn_mode && (mode_q == SET_HOUR) && bus.btn_inc);

  always_comb begin
    mode_nxt = RUN;
    if (bus.btn_mode) begin
      case (mode_q)
        RUN:      mode_nxt = SET_HOUR;
        SET_HOUR: mode_nxt = SET_MIN;
        default:  mode_nxt = RUN;
      endcase
    end else begin
      case (mode_q)
        RUN, SET_HOUR, SET_MIN: mode_nxt = mode_q;
        default:                mode_nxt = RUN;
      endcase
    end
  end

  // 12 -> 01 -> ... -> 09 -> 10 -> 11 -> 12, meridiem flips entering 12.
  always_comb begin
    hour1_nxt = hour1_q + 4'd1;
    hour2_nxt = hour2_q;
    ampm_nxt  = ampm_q;
    if (hour2_q == 4'd1 && hour1_q == 4'd2) begin
      hour2_nxt = 4'd0;
      hour1_nxt = 4'd1;
    end else if (hour1_q == 4'd9) begin
      hour2_nxt = 4'd1;
      hour1_nxt = 4'd0;
    end else if (hour2_q == 4'd1 && hour1_q == 4'd1) begin
      ampm_nxt = ~ampm_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc   <= '0;
      tick_q  <= 1'b0;
      mode_q  <= RUN;
      sec1_q  <= 4'd0;
      sec2_q  <= 4'd0;
      min1_q  <= 4'd0;
      min2_q  <= 4'd0;
      hour1_q <= 4'd2;
      hour2_q <= 4'd1;
      ampm_q  <= 1'b0;
    end else begin
      mode_q <= mode_nxt;

      // Leaving SET_MIN restarts the second so the first tick is a full period away.
      if (exit_set) begin
        presc  <= '0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= (presc == PRESC_MAX);
        presc  <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      end

      if (exit_set) begin
        sec1_q <= 4'd0;
        sec2_q <= 4'd0;
      end else if (adv_sec) begin
        if (sec1_q == 4'd9) begin
          sec1_q <= 4'd0;
          sec2_q <= (sec2_q == 4'd5) ? 4'd0 : sec2_q + 4'd1;
        end else begin
          sec1_q <= sec1_q + 4'd1;
        end
      end

      if (inc_min) begin
        if (min1_q == 4'd9) begin
          min1_q <= 4'd0;
          min2_q <= (min2_q == 4'd5) ? 4'd0 : min2_q + 4'd1;
        end else begin
          min1_q <= min1_q + 4'd1;
        end
      end

      if (inc_hour) begin
        hour1_q <= hour1_nxt;
        hour2_q <= hour2_nxt;
        ampm_q  <= ampm_nxt;
      end
    end
  end

  assign bus.sec1     = sec1_q;
  assign bus.sec2     = sec2_q;
  assign bus.min1     = min1_q;
  assign bus.min2     = min2_q;
  assign bus.hour1    = hour1_q;
  assign bus.hour2    = hour2_q;
  assign bus.ampm     = ampm_q;
  assign bus.mode     = mode_q;
  assign bus.tick_1hz = tick_q;

`ifdef CLOCK_SET_BLINK_EN
  logic       blink_tog;
  logic       tog_nxt;
  logic [3:0] blank_q;

  always_comb begin
    tog_nxt = blink_tog;
    if (bus.btn_mode && mode_nxt != RUN) tog_nxt = 1'b0;
    else if (tick_q)                     tog_nxt = ~blink_tog;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_tog <= 1'b0;
      blank_q   <= 4'b0000;
    end else begin
      blink_tog <= tog_nxt;
      if (mode_nxt == SET_HOUR && !tog_nxt)     blank_q <= 4'b1100;
      else if (mode_nxt == SET_MIN && !tog_nxt) blank_q <= 4'b0011;
      else                                      blank_q <= 4'b0000;
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = 4'b0000;
`endif

endmodule
